// File: rtl/irq_controller_if.sv
// Bus bundle for irq_controller.
// Carries the interrupt lines, the config register port, the core-side
// handshake (ack/ret/irq/cause) and the source-side completion pulse.
//   master : the surrounding system (sources, config master, core)
//   slave  : the interrupt controller
interface irq_controller_if;
  logic [15:0] irq_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [15:0] cfg_wdata_i;
  logic [15:0] cfg_rdata_o;
  logic        irq_ack_i;
  logic        irq_ret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  modport master (
    output irq_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_ret_i,
    input  cfg_rdata_o, irq_o, irq_cause_o, irq_ret_o, busy_o
  );

  modport slave (
    input  irq_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i, irq_ret_i,
    output cfg_rdata_o, irq_o, irq_cause_o, irq_ret_o, busy_o
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: 16-line fixed-priority, non-nesting interrupt controller.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus    : irq_controller_if.slave
//            irq_i        raw lines, bit 0 highest priority
//            cfg_*        register port (0 MASK, 1 EDGE, 2 PEND W1C, 3 ACTIVE ro)
//            irq_ack_i    core took the trap
//            irq_ret_i    core executed interrupt return
//            irq_o        request to core (registered)
//            irq_cause_o  {12'h800, ACTIVE, 4'h0} in REQ/SERVICE (registered)
//            irq_ret_o    one-hot completion pulse in DONE (registered)
//            busy_o       high outside IDLE (registered)
module irq_controller (
  input  logic           clk_i,
  input  logic           rst_i,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE, DONE} state_t;

  state_t      state;
  logic [15:0] mask, edge_cfg, latch, prev, active;
  logic        irq_q, busy_q;
  logic [31:0] cause_q;
  logic [15:0] ret_q;

  logic [15:0] pending, eligible, sel, latch_set, latch_clr;

  assign pending   = (edge_cfg & latch) | (~edge_cfg & bus.irq_i);
  assign eligible  = pending & mask;
  // Isolate lowest set bit: lowest index wins.
  assign sel       = eligible & (~eligible + 16'd1);
  assign latch_set = bus.irq_i & ~prev & edge_cfg;

  always_comb begin
    latch_clr = '0;
    if (bus.cfg_we_i && bus.cfg_addr_i == 2'd2) latch_clr = latch_clr | bus.cfg_wdata_i;
    if (state == DONE)                          latch_clr = latch_clr | active;
  end

  always_comb begin
    bus.cfg_rdata_o = '0;
    case (bus.cfg_addr_i)
      2'd0:    bus.cfg_rdata_o = mask;
      2'd1:    bus.cfg_rdata_o = edge_cfg;
      2'd2:    bus.cfg_rdata_o = pending;
      default: bus.cfg_rdata_o = active;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mask     <= '0;
      edge_cfg <= '0;
      latch    <= '0;
      prev     <= '0;
      active   <= '0;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
      cause_q  <= '0;
      ret_q    <= '0;
    end else begin
      prev  <= bus.irq_i;
      // A new edge beats any same-cycle clear.
      latch <= (latch & ~latch_clr) | latch_set;

      if (bus.cfg_we_i) begin
        case (bus.cfg_addr_i)
          2'd0:    mask     <= bus.cfg_wdata_i;
          2'd1:    edge_cfg <= bus.cfg_wdata_i;
          default: ;
        endcase
      end

      unique case (state)
        IDLE: begin
          if (|eligible) begin
            state   <= REQ;
            active  <= sel;
            irq_q   <= 1'b1;
            busy_q  <= 1'b1;
            cause_q <= {12'h800, sel, 4'h0};
          end
        end
        REQ: begin
          if (bus.irq_ack_i) begin
            state <= SERVICE;
            irq_q <= 1'b0;
          end else if (!(|(eligible & active))) begin
            // Request withdrawn before the core took it.
            state   <= IDLE;
            active  <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= '0;
          end
        end
        SERVICE: begin
          // Committed: only the return moves us on.
          if (bus.irq_ret_i) begin
            state   <= DONE;
            ret_q   <= active;
            cause_q <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          active <= '0;
          ret_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq_o       = irq_q;
  assign bus.irq_cause_o = cause_q;
  assign bus.irq_ret_o   = ret_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: reset state, level/edge service,
// priority, W1C vs edge race, withdrawal, no-abort in SERVICE, reset abandon.
module tb_irq_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  irq_controller_if bus();

  irq_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input string tag, input logic [15:0] exp);
    bus.cfg_addr_i = a;
    #1;
    chk(tag, {16'h0, bus.cfg_rdata_o}, {16'h0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = a; bus.cfg_wdata_i = d;
    tick();
    bus.cfg_we_i = 1'b0; bus.cfg_wdata_i = '0;
  endtask

  task automatic outs(input string tag, input logic irq, input logic [31:0] cause,
                      input logic [15:0] ret, input logic busy);
    chk({tag, ".irq"},   {31'h0, bus.irq_o}, {31'h0, irq});
    chk({tag, ".cause"}, bus.irq_cause_o, cause);
    chk({tag, ".ret"},   {16'h0, bus.irq_ret_o}, {16'h0, ret});
    chk({tag, ".busy"},  {31'h0, bus.busy_o}, {31'h0, busy});
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_i = '0; bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_wdata_i = '0;
    bus.irq_ack_i = 0; bus.irq_ret_i = 0;
    tick(); tick();
    rst = 1'b0;
    outs("reset", 0, 0, 0, 0);
    rd(0, "reset.mask", 16'h0);
    rd(1, "reset.edge", 16'h0);
    rd(3, "reset.active", 16'h0);

    // No request while MASK is zero
    bus.irq_i = 16'hFFFF;
    tick(); tick();
    outs("mask0", 0, 0, 0, 0);
    bus.irq_i = '0;
    // ack outside REQ ignored
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    outs("ack_idle", 0, 0, 0, 0);

    // Basic level service on line 2
    wr(0, 16'h0005);
    bus.irq_i = 16'h0004;
    tick();
    outs("lvl.req", 1, 32'h8000_0040, 0, 1);
    rd(3, "lvl.active", 16'h0004);
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;   // ret outside SERVICE ignored
    outs("ret_in_req", 1, 32'h8000_0040, 0, 1);
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    outs("lvl.svc", 0, 32'h8000_0040, 0, 1);
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    bus.irq_i = '0;
    outs("lvl.done", 0, 0, 16'h0004, 1);
    rd(3, "lvl.done_active", 16'h0004);
    tick();
    outs("lvl.idle", 0, 0, 0, 0);

    // Priority: lines 1 and 2 together, line 1 first, then line 2
    wr(0, 16'hFFFF);
    bus.irq_i = 16'h0006;
    tick();
    rd(3, "prio.active1", 16'h0002);
    outs("prio.req1", 1, 32'h8000_0020, 0, 1);
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    bus.irq_i = 16'h0004;
    outs("prio.done1", 0, 0, 16'h0002, 1);
    tick();
    outs("prio.gap", 0, 0, 0, 0);
    tick();
    outs("prio.req2", 1, 32'h8000_0040, 0, 1);
    rd(3, "prio.active2", 16'h0004);
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    bus.irq_i = '0;
    outs("prio.done2", 0, 0, 16'h0004, 1);
    tick();

    // Edge line 3: latched pulse, cleared on completion
    wr(1, 16'h0008);
    bus.irq_i = 16'h0008; tick(); bus.irq_i = '0;
    rd(2, "edge.pend", 16'h0008);
    tick();
    outs("edge.req", 1, 32'h8000_0080, 0, 1);
    rd(2, "edge.pend_held", 16'h0008);
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    outs("edge.done", 0, 0, 16'h0008, 1);
    tick();
    rd(2, "edge.pend_clr", 16'h0000);

    // W1C race vs new edge (mask off to keep FSM idle)
    wr(0, 16'h0000);
    bus.irq_i = 16'h0008; tick(); bus.irq_i = '0; tick();
    rd(2, "w1c.pre", 16'h0008);
    bus.irq_i = 16'h0008;
    wr(2, 16'h0008);
    rd(2, "w1c.race", 16'h0008);
    wr(2, 16'h0008);
    rd(2, "w1c.clear", 16'h0000);
    bus.irq_i = '0;
    wr(1, 16'h0000);

    // Withdrawal in REQ
    wr(0, 16'hFFFF);
    bus.irq_i = 16'h0002; tick();
    outs("wd.req", 1, 32'h8000_0020, 0, 1);
    bus.irq_i = '0; tick();
    outs("wd.idle", 0, 0, 0, 0);
    rd(3, "wd.active", 16'h0000);
    tick();
    outs("wd.noret", 0, 0, 0, 0);

    // Ack beats same-cycle withdrawal
    bus.irq_i = 16'h0002; tick();
    bus.irq_i = '0; bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    outs("ackwd.svc", 0, 32'h8000_0020, 0, 1);
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    outs("ackwd.done", 0, 0, 16'h0002, 1);
    tick();

    // No abort in SERVICE; higher line waits, masked off
    bus.irq_i = 16'h0010; tick();
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    bus.irq_i = 16'h0011;
    wr(0, 16'h0000);
    tick();
    outs("noab.svc", 0, 32'h8000_0100, 0, 1);
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    outs("noab.done", 0, 0, 16'h0010, 1);
    tick(); tick();
    outs("noab.idle", 0, 0, 0, 0);
    bus.irq_i = '0;

    // Reset mid-service
    wr(0, 16'hFFFF);
    bus.irq_i = 16'h0001; tick();
    bus.irq_ack_i = 1; tick(); bus.irq_ack_i = 0;
    bus.irq_i = '0;
    outs("rst.svc", 0, 32'h8000_0010, 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    outs("rst.after", 0, 0, 0, 0);
    rd(3, "rst.active", 16'h0000);
    rd(0, "rst.mask", 16'h0000);
    bus.irq_ret_i = 1; tick(); bus.irq_ret_i = 0;
    outs("rst.ret1", 0, 0, 0, 0);
    tick();
    outs("rst.ret2", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-002 SHALL have ports:
 clk_i  in  1  clock, all state on rising edge
 rst_i  in  1  synchronous active-high reset
 irq_i  in  16  raw interrupt lines, index 0 = highest priority
 cfg_we_i  in  1  config write strobe
 cfg_addr_i  in  2  register select: 0 MASK, 1 EDGE, 2 PEND, 3 ACTIVE
 cfg_wdata_i  in  16  write data
 cfg_rdata_o  out  16  read data, combinational from cfg_addr_i
 irq_ack_i  in  1  core has taken the trap
 irq_ret_i  in  1  core executed interrupt return
 irq_o  out  1  interrupt request to core
 irq_cause_o  out  32  cause word
 irq_ret_o  out  16  one-hot completion pulse to sources
 busy_o  out  1  high in any state other than IDLE

Function
REQ-003 MASK (rw): bit=1 enables line; EDGE (rw): bit=1 edge-triggered, 0 level; PEND: read = pending vector, write = 1-to-clear edge latches; ACTIVE (ro): one-hot of the line held in REQ/SERVICE/DONE, else 0; writes to ACTIVE are ignored.
REQ-004 Edge latch bit i SHALL set on a cycle where irq_i[i]=1 and its registered previous sample=0 and EDGE[i]=1.
REQ-005 Edge latch set SHALL win over a same-cycle W1C or DONE clear.
REQ-006 pending[i] SHALL equal EDGE[i] ? latch[i] : irq_i[i]; eligible = pending & MASK.
REQ-007 Selection SHALL be the lowest eligible index (fixed priority), made only in IDLE and held registered until return to IDLE.
REQ-008 FSM states IDLE, REQ, SERVICE, DONE.
REQ-009 IDLE: if eligible != 0, capture one-hot selection into ACTIVE and go to REQ; irq_o rises the cycle after eligibility is first visible.
REQ-010 REQ: irq_o=1; irq_ack_i=1 -> SERVICE; else if the selected bit of eligible drops -> IDLE (request withdrawn, no irq_ret_o pulse); ack has priority over withdrawal in the same cycle.
REQ-011 SERVICE: irq_o=0; MASK/level changes SHALL NOT abort; irq_ret_i=1 -> DONE.
REQ-012 DONE: irq_ret_o = ACTIVE for exactly one cycle; clear the selected edge latch; go to IDLE.
REQ-013 irq_ret_i outside SERVICE and irq_ack_i outside REQ SHALL be ignored.
REQ-014 irq_cause_o = {12'h800, ACTIVE, 4'h0} in REQ and SERVICE, 32'h0 otherwise.
REQ-015 No nesting: a higher-priority line arriving in REQ or SERVICE SHALL wait; it is selected in IDLE, so the next irq_o can rise at the earliest 2 cycles after DONE.
REQ-016 Config writes SHALL take effect the next cycle in any state; reads return the current register value.

Reset
REQ-017 On rst_i=1 at a clock edge: state IDLE; MASK, EDGE, latches, ACTIVE and the previous-sample register = 0; irq_o=0, irq_ret_o=0, irq_cause_o=0, busy_o=0.
REQ-018 Reset mid-service SHALL abandon the interrupt without an irq_ret_o pulse.
REQ-019 After reset no request SHALL be raised until MASK is written non-zero.

Verification
REQ-020 MASK=16'h0005, EDGE=0, irq_i=16'h0004 -> irq_o=1 next cycle, cause 32'h80000040; ack, ret -> irq_ret_o=16'h0004 for one cycle.
REQ-021 MASK=FFFF, irq_i=16'h0006 at the same time -> ACTIVE=16'h0002; after DONE, line 2 is served next.
REQ-022 EDGE[3]=1, one-cycle pulse on irq_i[3] -> PEND=16'h0008 held; service completes -> PEND=0; W1C of 16'h0008 on a same-cycle new edge -> bit stays 1.
REQ-023 Level line 1 in REQ, irq_i[1] drops before ack -> IDLE next cycle, irq_o=0, irq_ret_o stays 0.
REQ-024 In SERVICE write MASK=0, raise irq_i[0] -> irq_o stays 0; ret still yields the irq_ret_o pulse for the original line.
REQ-025 rst_i asserted in SERVICE -> all outputs 0 next cycle; irq_ret_i afterwards produces no pulse.
